// File: rtl/kappa3_mem_pkg.sv
// Shared definitions for the KAPPA3 data-memory responder.
//   - funct3 access size/sign codes (ir[14:12])
//   - responder FSM state encoding
//   - data word width
package kappa3_mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/kappa3_mem_bank.sv
// Word-organised byte-lane RAM for the KAPPA3 data memory.
// Ports:
//   clock  in   write clock (rising edge)
//   we     in   write enable
//   be     in   4-bit byte-lane enable, bit i writes data[8*i+7:8*i]
//   index  in   word index, shared by read and write
//   wdata  in   write word
//   rdata  out  asynchronous read of the word at index
// Contents are not initialised or cleared by reset.
module kappa3_mem_bank
    import kappa3_mem_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clock,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[index][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/kappa3_mem_responder.sv
// Responder end of the KAPPA3 data-memory port.
// Accepts a held mem_read/mem_write level request in IDLE, latches the
// request, waits WAIT_CYCLES states, then pulses mem_ready for one cycle
// with rddata/mem_err valid. Store data is lane-replicated; load data is
// shifted and sign/zero extended to a register-aligned value.
// Ports:
//   clock, reset       clock; asynchronous active-high reset
//   mem_read/mem_write request levels (write wins if both)
//   mem_wrbits         byte-lane write mask, used as supplied
//   addr, wrdata       byte address and register-aligned store data
//   funct3             access size/sign
//   rddata             extracted load data (0 for stores/errors)
//   mem_ready          one-cycle completion pulse
//   mem_err            range (and optional alignment) error, with mem_ready
//   dbg_state          current FSM state
// Optional: define KAPPA3_MEM_MISALIGN_CHECK_EN to flag misaligned
// halfword/word accesses as errors.
module kappa3_mem_responder
    import kappa3_mem_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_wrbits,
    input  logic [31:0]       addr,
    input  logic [31:0]       wrdata,
    input  logic [2:0]        funct3,
    output logic [31:0]       rddata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic [1:0]        dbg_state
);

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [31:0] lat_addr, lat_wrdata;
    logic [3:0]  lat_wrbits;
    logic [2:0]  lat_f3;
    logic        lat_write;

    logic        req;
    logic        go_resp;
    logic [31:0] sel_addr, sel_wrdata;
    logic [3:0]  sel_wrbits;
    logic [2:0]  sel_f3;
    logic        sel_write;
    logic        acc_err;
    logic        we;
    logic [31:0] store_word, ram_word, sh_b, sh_h, ext;

    assign req = mem_read | mem_write;

    // With zero wait states the RAM write lands on the accepting edge, so
    // the datapath works from the live inputs in IDLE and latches elsewhere.
    always_comb begin
        if (state == IDLE) begin
            sel_addr   = addr;
            sel_wrdata = wrdata;
            sel_wrbits = mem_wrbits;
            sel_f3     = funct3;
            sel_write  = mem_write;
        end else begin
            sel_addr   = lat_addr;
            sel_wrdata = lat_wrdata;
            sel_wrbits = lat_wrbits;
            sel_f3     = lat_f3;
            sel_write  = lat_write;
        end
    end

    always_comb begin
        acc_err = |sel_addr[31:ADDR_W+2];
`ifdef KAPPA3_MEM_MISALIGN_CHECK_EN
        if (sel_f3[1:0] == 2'b01 && sel_addr[0])
            acc_err = 1'b1;
        if (sel_f3[1:0] == 2'b10 && sel_addr[1:0] != 2'b00)
            acc_err = 1'b1;
`endif
    end

    always_comb begin
        case (sel_f3)
            F3_B:    store_word = {4{sel_wrdata[7:0]}};
            F3_H:    store_word = {2{sel_wrdata[15:0]}};
            default: store_word = sel_wrdata;
        endcase
    end

    kappa3_mem_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clock (clock),
        .we    (we),
        .be    (sel_wrbits),
        .index (sel_addr[ADDR_W+1:2]),
        .wdata (store_word),
        .rdata (ram_word)
    );

    // Halfwords shift by whole halves only: addr[0] selects no lane.
    always_comb begin
        sh_b = ram_word >> {sel_addr[1:0], 3'b000};
        sh_h = ram_word >> {sel_addr[1], 4'b0000};
        case (sel_f3)
            F3_B:    ext = {{24{sh_b[7]}}, sh_b[7:0]};
            F3_BU:   ext = {24'd0, sh_b[7:0]};
            F3_H:    ext = {{16{sh_h[15]}}, sh_h[15:0]};
            F3_HU:   ext = {16'd0, sh_h[15:0]};
            default: ext = ram_word;
        endcase
    end

    // Next state and outputs.
    always_comb begin
        next_state = state;
        mem_ready  = 1'b0;
        mem_err    = 1'b0;
        rddata     = '0;
        case (state)
            IDLE: begin
                if (req)
                    next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 4'(WAIT_CYCLES))
                    next_state = RESP;
            end
            RESP: begin
                next_state = IDLE;
                mem_ready  = 1'b1;
                mem_err    = acc_err;
                if (!lat_write && !acc_err)
                    rddata = ext;
            end
            default: next_state = IDLE;
        endcase
    end

    assign go_resp   = (next_state == RESP) && (state != RESP);
    assign we        = go_resp && sel_write && !acc_err;
    assign dbg_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wrdata <= '0;
            lat_wrbits <= '0;
            lat_f3     <= '0;
            lat_write  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && req) begin
                cnt        <= '0;
                lat_addr   <= addr;
                lat_wrdata <= wrdata;
                lat_wrbits <= mem_wrbits;
                lat_f3     <= funct3;
                lat_write  <= mem_write;
            end else if (state == WAIT) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_kappa3_mem_responder.sv
// Directed bench for kappa3_mem_responder. Two instances share the data
// inputs: u_w1 with WAIT_CYCLES=1 and u_w3 with WAIT_CYCLES=3.
// Request handshake: the bench raises mem_read/mem_write (level) and holds
// it until mem_ready is seen high, then drops it before the next edge.
module tb_kappa3_mem_responder;
    import kappa3_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst1, rst3;
    logic        rd1, wr1, rd3, wr3;
    logic [3:0]  wrbits;
    logic [31:0] addr, wrdata;
    logic [2:0]  f3;
    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3, err1, err3;
    logic [1:0]  st1, st3;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_rd;
    logic        got_err;
    int          got_lat;
    logic        low_after;

    always #5 clk = ~clk;

    kappa3_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(1)) u_w1 (
        .clock(clk), .reset(rst1), .mem_read(rd1), .mem_write(wr1),
        .mem_wrbits(wrbits), .addr(addr), .wrdata(wrdata), .funct3(f3),
        .rddata(rdata1), .mem_ready(ready1), .mem_err(err1), .dbg_state(st1)
    );

    kappa3_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(3)) u_w3 (
        .clock(clk), .reset(rst3), .mem_read(rd3), .mem_write(wr3),
        .mem_wrbits(wrbits), .addr(addr), .wrdata(wrdata), .funct3(f3),
        .rddata(rdata3), .mem_ready(ready3), .mem_err(err3), .dbg_state(st3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction on instance sel (1 or 3). Returns data, error flag,
    // cycles from accepting edge to mem_ready (99 on timeout) and whether
    // mem_ready was low one cycle later.
    task automatic txn(input int sel, input bit is_wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] bits, input logic [2:0] code);
        bit rdy = 1'b0;
        @(negedge clk);
        addr = a; wrdata = d; wrbits = bits; f3 = code;
        if (sel == 1) begin rd1 = !is_wr; wr1 = is_wr; end
        else          begin rd3 = !is_wr; wr3 = is_wr; end
        @(posedge clk);
        got_lat = 0;
        while (!rdy && got_lat < 20) begin
            @(posedge clk);
            got_lat++;
            #1;
            rdy = (sel == 1) ? ready1 : ready3;
        end
        if (!rdy) got_lat = 99;
        got_rd  = (sel == 1) ? rdata1 : rdata3;
        got_err = (sel == 1) ? err1 : err3;
        rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        @(posedge clk);
        #1;
        low_after = (sel == 1) ? !ready1 : !ready3;
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        wrbits = '0; addr = '0; wrdata = '0; f3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready1", {31'd0, ready1}, 32'd0);
        check("rst_err1",   {31'd0, err1},   32'd0);
        check("rst_rd1",    rdata1,          32'd0);
        check("rst_state1", {30'd0, st1},    {30'd0, IDLE});
        check("rst_ready3", {31'd0, ready3}, 32'd0);
        check("rst_state3", {30'd0, st3},    {30'd0, IDLE});
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;

        // Full word store, latency and pulse width.
        txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, F3_W);
        check("sw_lat",   got_lat,            32'd2);
        check("sw_pulse", {31'd0, low_after}, 32'd1);
        check("sw_err",   {31'd0, got_err},   32'd0);
        check("sw_rd",    got_rd,             32'd0);
        txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, F3_W);
        check("lw_lat",   got_lat,            32'd2);
        check("lw_rd",    got_rd,             32'hDEADBEEF);
        check("lw_err",   {31'd0, got_err},   32'd0);

        // Byte store into the top lane, signed/unsigned byte loads.
        txn(1, 1'b1, 32'h13, 32'h000000A5, 4'b1000, F3_B);
        txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, F3_W);
        check("sb_word", got_rd, 32'hA5ADBEEF);
        txn(1, 1'b0, 32'h13, 32'h0, 4'b0000, F3_B);
        check("lb",  got_rd, 32'hFFFFFFA5);
        txn(1, 1'b0, 32'h13, 32'h0, 4'b0000, F3_BU);
        check("lbu", got_rd, 32'h000000A5);
        txn(1, 1'b0, 32'h11, 32'h0, 4'b0000, F3_BU);
        check("lbu_lane1", got_rd, 32'h000000BE);

        // Halfword store into the upper half, signed/unsigned half loads.
        txn(1, 1'b1, 32'h20, 32'h00000000, 4'b1111, F3_W);
        txn(1, 1'b1, 32'h22, 32'h00008001, 4'b1100, F3_H);
        txn(1, 1'b0, 32'h20, 32'h0, 4'b0000, F3_W);
        check("sh_word", got_rd, 32'h80010000);
        txn(1, 1'b0, 32'h22, 32'h0, 4'b0000, F3_H);
        check("lh",  got_rd, 32'hFFFF8001);
        txn(1, 1'b0, 32'h22, 32'h0, 4'b0000, F3_HU);
        check("lhu", got_rd, 32'h00008001);

        // Out-of-range accesses alias onto word 0 in the index bits.
        txn(1, 1'b1, 32'h0, 32'h11223344, 4'b1111, F3_W);
        txn(1, 1'b0, 32'h00004000, 32'h0, 4'b0000, F3_W);
        check("oor_lw_err", {31'd0, got_err}, 32'd1);
        check("oor_lw_rd",  got_rd,           32'd0);
        txn(1, 1'b1, 32'h00004000, 32'hFFFFFFFF, 4'b1111, F3_W);
        check("oor_sw_err", {31'd0, got_err}, 32'd1);
        txn(1, 1'b0, 32'h0, 32'h0, 4'b0000, F3_W);
        check("oor_word0", got_rd, 32'h11223344);
        check("oor_word0_err", {31'd0, got_err}, 32'd0);

        // Misaligned word load and halfword store.
        txn(1, 1'b1, 32'h30, 32'h0BADF00D, 4'b1111, F3_W);
        txn(1, 1'b0, 32'h31, 32'h0, 4'b0000, F3_W);
`ifdef KAPPA3_MEM_MISALIGN_CHECK_EN
        check("mis_lw_err", {31'd0, got_err}, 32'd1);
        check("mis_lw_rd",  got_rd,           32'd0);
`else
        check("mis_lw_err", {31'd0, got_err}, 32'd0);
        check("mis_lw_rd",  got_rd,           32'h0BADF00D);
`endif
        txn(1, 1'b1, 32'h21, 32'h00001234, 4'b0011, F3_H);
`ifdef KAPPA3_MEM_MISALIGN_CHECK_EN
        check("mis_sh_err", {31'd0, got_err}, 32'd1);
`else
        check("mis_sh_err", {31'd0, got_err}, 32'd0);
`endif
        txn(1, 1'b0, 32'h20, 32'h0, 4'b0000, F3_W);
`ifdef KAPPA3_MEM_MISALIGN_CHECK_EN
        check("mis_sh_word", got_rd, 32'h80010000);
`else
        check("mis_sh_word", got_rd, 32'h80011234);
`endif

        // WAIT_CYCLES=3 latency, then reset in the middle of WAIT.
        txn(3, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1111, F3_W);
        check("w3_lat", got_lat, 32'd4);
        @(negedge clk);
        addr = 32'h30; wrdata = 32'h12345678; wrbits = 4'b1111; f3 = F3_W;
        wr3 = 1'b1;
        @(posedge clk);             // accepting edge
        repeat (2) @(posedge clk);
        #1;
        check("w3_mid_state", {30'd0, st3}, {30'd0, WAIT});
        @(negedge clk);
        rst3 = 1'b1;
        wr3  = 1'b0;
        #1;
        check("w3_rst_state", {30'd0, st3},    {30'd0, IDLE});
        check("w3_rst_ready", {31'd0, ready3}, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        got_lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ready3) got_lat++;
        end
        check("w3_no_pulse", got_lat, 32'd0);
        txn(3, 1'b0, 32'h30, 32'h0, 4'b0000, F3_W);
        check("w3_prior", got_rd, 32'hCAFEF00D);
        check("w3_prior_lat", got_lat, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
